// File: rtl/gfx_fill_master.sv
// Playfield fill engine: writes one byte value to a run of bus addresses,
// optionally reads the run back and counts bytes that differ from the fill value.
module gfx_fill_master #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_LEN    = 1024
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] base_addr,
  input  logic [10:0] length,
  input  logic [7:0]  fill_data,
  input  logic        verify,
  input  logic        wait_vb,
  input  logic        vblank,
  output logic        cs_l,
  output logic        we_l,
  output logic [15:0] addr,
  output logic [7:0]  wr_data,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 11;
  localparam logic [LW-1:0] MAX_LEN_W   = LW'(MAX_LEN);
  localparam logic [LW-1:0] DRAIN_LAST  = LW'(RD_LATENCY - 1);
  localparam logic [DW-1:0] ERR_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state;
  logic [AW-1:0]   base_q;
  logic [LW-1:0]   len_q;
  logic [DW-1:0]   fill_q;
  logic            verify_q;
  logic            wait_vb_q;
  logic [LW-1:0]   idx;
  logic [RD_LATENCY-1:0] pipe;

  logic [LW-1:0]   len_clamp_c;
  logic            last_c;
  logic            rd_strobe_c;
  logic            mismatch_c;

  // Job length clamp, end-of-run detect and read-compare qualification
  always_comb begin
    len_clamp_c = (length > MAX_LEN_W) ? MAX_LEN_W : length;
    last_c      = (idx == LW'(len_q - LW'(1)));
    rd_strobe_c = (state == READ);
    mismatch_c  = pipe[RD_LATENCY-1] && (rd_data != fill_q);
  end

  // Control FSM with registered bus outputs; pipe tracks reads awaiting their data
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= IDLE;
      cs_l      <= 1'b1;
      we_l      <= 1'b1;
      addr      <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      base_q    <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      verify_q  <= 1'b0;
      wait_vb_q <= 1'b0;
      idx       <= '0;
      pipe      <= '0;
    end else if (abort && (state != IDLE)) begin
      // Abort drops the job and any outstanding compares; partial count is kept
      state <= IDLE;
      cs_l  <= 1'b1;
      we_l  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      pipe  <= '0;
    end else begin
      done    <= 1'b0;
      pipe[0] <= rd_strobe_c;
      for (int k = 1; k < RD_LATENCY; k++) pipe[k] <= pipe[k-1];
      if (mismatch_c && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            base_q    <= base_addr;
            len_q     <= len_clamp_c;
            fill_q    <= fill_data;
            verify_q  <= verify;
            wait_vb_q <= wait_vb;
            err_cnt   <= '0;
            busy      <= 1'b1;
            idx       <= '0;
            addr      <= base_addr;
            wr_data   <= fill_data;
            if (len_clamp_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (wait_vb) begin
              state <= WAIT_VB;
            end else begin
              state <= WRITE;
              cs_l  <= 1'b0;
              we_l  <= 1'b0;
            end
          end
        end
        WAIT_VB: begin
          if (vblank || !wait_vb_q) begin
            state <= WRITE;
            cs_l  <= 1'b0;
            we_l  <= 1'b0;
            addr  <= base_q;
            idx   <= '0;
          end
        end
        WRITE: begin
          if (last_c) begin
            idx <= '0;
            if (verify_q) begin
              state <= READ;
              we_l  <= 1'b1;
              addr  <= base_q;
            end else begin
              state <= DONE;
              cs_l  <= 1'b1;
              we_l  <= 1'b1;
              done  <= 1'b1;
            end
          end else begin
            idx  <= idx + LW'(1);
            addr <= addr + 16'd1;
          end
        end
        READ: begin
          if (last_c) begin
            state <= DRAIN;
            cs_l  <= 1'b1;
            we_l  <= 1'b1;
            idx   <= '0;
          end else begin
            idx  <= idx + LW'(1);
            addr <= addr + 16'd1;
          end
        end
        DRAIN: begin
          if (idx == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + LW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cs_l  <= 1'b1;
          we_l  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_fill_master.sv
// Directed bench for gfx_fill_master with a one-cycle-latency playfield RAM model.
module tb_gfx_fill_master;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start, abort, verify, wait_vb, vblank;
  logic [15:0] base_addr;
  logic [10:0] length;
  logic [7:0]  fill_data;
  logic        cs_l, we_l, busy, done;
  logic [15:0] addr;
  logic [7:0]  wr_data, rd_data, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the most recent job
  int n_wr, n_rd, first_wr, done_cyc, done_cnt;
  int busy_first, busy_last, busy_cnt, addr_errs;
  logic [7:0] err_final;
  logic s_cs, s_we, s_busy, s_done;
  logic [15:0] s_addr;
  logic [7:0]  s_wd, s_err;

  // RAM fault injection controls
  logic        all_bad = 1'b0;
  logic        bad_en  = 1'b0;
  logic [15:0] bad_addr = 16'h0000;
  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  gfx_fill_master #(.RD_LATENCY(1), .MAX_LEN(1024)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .fill_data(fill_data),
    .verify(verify), .wait_vb(wait_vb), .vblank(vblank),
    .cs_l(cs_l), .we_l(we_l), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  // Playfield RAM: write on strobe, read data valid one cycle after strobe
  always @(posedge clk) begin
    if (!cs_l && !we_l) mem[addr] <= wr_data;
    if (!cs_l && we_l) begin
      if (all_bad) rd_data <= ~mem[addr];
      else if (bad_en && addr == bad_addr) rd_data <= 8'h00;
      else rd_data <= mem[addr];
    end
  end

  // Launch one job and watch the bus for max_cyc cycles after the start edge
  task automatic run_job(input logic [15:0] b, input logic [10:0] l, input logic [7:0] f,
                         input logic v, input logic w, input int vb_delay, input int abort_cyc,
                         input int start_cyc, input int rst_cyc, input int max_cyc);
    logic [15:0] exp_a;
    n_wr = 0; n_rd = 0; first_wr = -1; done_cyc = -1; done_cnt = 0;
    busy_first = -1; busy_last = -1; busy_cnt = 0; addr_errs = 0;
    base_addr = b; length = l; fill_data = f; verify = v; wait_vb = w;
    vblank = 1'b0; abort = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (!cs_l && !we_l) begin
        if (first_wr < 0) first_wr = cyc;
        exp_a = b + 16'(n_wr);
        if (addr !== exp_a || wr_data !== f) addr_errs++;
        n_wr++;
      end
      if (!cs_l && we_l) begin
        exp_a = b + 16'(n_rd);
        if (addr !== exp_a || wr_data !== f) addr_errs++;
        n_rd++;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
        busy_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == rst_cyc + 1) begin
        s_cs = cs_l; s_we = we_l; s_addr = addr; s_wd = wr_data;
        s_busy = busy; s_done = done; s_err = err_cnt;
      end
      vblank = w && (cyc >= vb_delay);
      abort  = (cyc == abort_cyc);
      start  = (cyc == start_cyc);
      if (cyc == start_cyc) begin
        base_addr = ~b;
        fill_data = ~f;
      end
      rst_l = !(cyc == rst_cyc);
    end
    start = 1'b0; abort = 1'b0; rst_l = 1'b1; vblank = 1'b0;
    err_final = err_cnt;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; start = 1'b0; abort = 1'b0; verify = 1'b0; wait_vb = 1'b0;
    vblank = 1'b0; base_addr = '0; length = '0; fill_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({cs_l, we_l, busy, done} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 1100", {cs_l, we_l, busy, done});
    end
    n_tests++;
    if (addr !== 16'h0 || wr_data !== 8'h0 || err_cnt !== 8'h0) begin
      n_fail++; $display("FAIL reset_data got addr=%h wd=%h err=%h want 0", addr, wr_data, err_cnt);
    end
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_write();
    run_job(16'h0000, 11'd4, 8'hA5, 1'b0, 1'b0, 0, -1, -1, -1, 10);
    n_tests++;
    if (n_wr !== 4 || first_wr !== 1 || addr_errs !== 0) begin
      n_fail++; $display("FAIL basic_writes got n=%0d first=%0d aerr=%0d want 4 1 0", n_wr, first_wr, addr_errs);
    end
    n_tests++;
    if (done_cyc !== 5 || done_cnt !== 1) begin
      n_fail++; $display("FAIL basic_done got cyc=%0d cnt=%0d want 5 1", done_cyc, done_cnt);
    end
    n_tests++;
    if (busy_first !== 1 || busy_last !== 5 || busy_cnt !== 5) begin
      n_fail++; $display("FAIL basic_busy got %0d..%0d cnt=%0d want 1..5 cnt=5", busy_first, busy_last, busy_cnt);
    end
  endtask

  task automatic test_verify_wrap();
    bad_en = 1'b1; bad_addr = 16'h0001;
    run_job(16'hFFFE, 11'd4, 8'h5A, 1'b1, 1'b0, 0, -1, -1, -1, 14);
    bad_en = 1'b0;
    n_tests++;
    if (n_wr !== 4 || n_rd !== 4 || addr_errs !== 0) begin
      n_fail++; $display("FAIL wrap_strobes got wr=%0d rd=%0d aerr=%0d want 4 4 0", n_wr, n_rd, addr_errs);
    end
    n_tests++;
    if (err_final !== 8'd1) begin
      n_fail++; $display("FAIL wrap_errcnt got %0d want 1", err_final);
    end
    n_tests++;
    if (done_cyc !== 10 || done_cnt !== 1) begin
      n_fail++; $display("FAIL wrap_done got cyc=%0d cnt=%0d want 10 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_verify_clean();
    run_job(16'h1234, 11'd5, 8'h3C, 1'b1, 1'b0, 0, -1, -1, -1, 16);
    n_tests++;
    if (err_final !== 8'd0 || done_cyc !== 12 || n_rd !== 5) begin
      n_fail++; $display("FAIL clean_verify got err=%0d done=%0d rd=%0d want 0 12 5", err_final, done_cyc, n_rd);
    end
  endtask

  task automatic test_length_bounds();
    run_job(16'h2000, 11'd2047, 8'h11, 1'b0, 1'b0, 0, -1, -1, -1, 1030);
    n_tests++;
    if (n_wr !== 1024 || done_cyc !== 1025 || addr_errs !== 0) begin
      n_fail++; $display("FAIL clamp got wr=%0d done=%0d aerr=%0d want 1024 1025 0", n_wr, done_cyc, addr_errs);
    end
    run_job(16'h3000, 11'd0, 8'h22, 1'b1, 1'b0, 0, -1, -1, -1, 5);
    n_tests++;
    if (n_wr !== 0 || n_rd !== 0 || done_cyc !== 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_len got wr=%0d rd=%0d done=%0d cnt=%0d want 0 0 1 1", n_wr, n_rd, done_cyc, done_cnt);
    end
    n_tests++;
    if (busy_first !== 1 || busy_cnt !== 1) begin
      n_fail++; $display("FAIL zero_busy got first=%0d cnt=%0d want 1 1", busy_first, busy_cnt);
    end
  endtask

  task automatic test_wait_vblank();
    run_job(16'h4000, 11'd3, 8'h77, 1'b0, 1'b1, 20, -1, -1, -1, 30);
    n_tests++;
    if (first_wr !== 21 || n_wr !== 3 || done_cyc !== 24) begin
      n_fail++; $display("FAIL vblank got first=%0d wr=%0d done=%0d want 21 3 24", first_wr, n_wr, done_cyc);
    end
  endtask

  task automatic test_abort();
    run_job(16'h5000, 11'd10, 8'hC3, 1'b0, 1'b0, 0, 3, 2, -1, 20);
    n_tests++;
    if (n_wr !== 3 || addr_errs !== 0) begin
      n_fail++; $display("FAIL abort_writes got wr=%0d aerr=%0d want 3 0", n_wr, addr_errs);
    end
    n_tests++;
    if (done_cnt !== 0 || busy_last !== 3 || busy_cnt !== 3) begin
      n_fail++; $display("FAIL abort_state got done=%0d blast=%0d bcnt=%0d want 0 3 3", done_cnt, busy_last, busy_cnt);
    end
    // Simultaneous start and abort in IDLE: abort wins
    base_addr = 16'h6000; length = 11'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || cs_l !== 1'b1) begin
      n_fail++; $display("FAIL abort_start got busy=%b cs_l=%b want 0 1", busy, cs_l);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_job(16'h7000, 11'd4, 8'h96, 1'b0, 1'b0, 0, -1, 3, -1, 12);
    n_tests++;
    if (n_wr !== 4 || addr_errs !== 0 || busy_cnt !== 5 || done_cnt !== 1) begin
      n_fail++; $display("FAIL busy_start got wr=%0d aerr=%0d bcnt=%0d done=%0d want 4 0 5 1", n_wr, addr_errs, busy_cnt, done_cnt);
    end
    run_job(16'h7100, 11'd2, 8'h42, 1'b0, 1'b0, 0, -1, -1, -1, 6);
    n_tests++;
    if (n_wr !== 2 || first_wr !== 1 || done_cyc !== 3 || addr_errs !== 0) begin
      n_fail++; $display("FAIL next_job got wr=%0d first=%0d done=%0d aerr=%0d want 2 1 3 0", n_wr, first_wr, done_cyc, addr_errs);
    end
  endtask

  task automatic test_reset_mid_read();
    all_bad = 1'b1;
    run_job(16'h8000, 11'd300, 8'h0F, 1'b1, 1'b0, 0, -1, -1, 310, 330);
    n_tests++;
    if ({s_cs, s_we, s_busy, s_done} !== 4'b1100 || s_addr !== 16'h0 || s_wd !== 8'h0 || s_err !== 8'h0) begin
      n_fail++; $display("FAIL rst_read got cs=%b we=%b b=%b d=%b a=%h wd=%h e=%h want 1 1 0 0 0 0 0",
                         s_cs, s_we, s_busy, s_done, s_addr, s_wd, s_err);
    end
    n_tests++;
    if (n_rd !== 10 || done_cnt !== 0) begin
      n_fail++; $display("FAIL rst_activity got rd=%0d done=%0d want 10 0", n_rd, done_cnt);
    end
  endtask

  task automatic test_saturation();
    run_job(16'h9000, 11'd300, 8'hF0, 1'b1, 1'b0, 0, -1, -1, -1, 610);
    all_bad = 1'b0;
    n_tests++;
    if (err_final !== 8'd255 || n_rd !== 300 || done_cyc !== 602) begin
      n_fail++; $display("FAIL saturate got err=%0d rd=%0d done=%0d want 255 300 602", err_final, n_rd, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_verify_wrap();
    test_verify_clean();
    test_length_bounds();
    test_wait_vblank();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
